// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared op/state encodings and default widths for the data-memory master
package dmem_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/dmem_master.sv
// rtl/dmem_master.sv - load/store/copy/fill initiator for the data memory; optional range check under DMEM_MASTER_WRAP_CHECK_EN
module dmem_master
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          mem_e,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do
);

  state_e        state_q;
  op_e           op_q;
  logic [AW-1:0] src_q, dst_q, cnt_q;
  logic [DW-1:0] data_q, wdata_q;
  logic          cmd_ready_q, rsp_valid_q, mem_e_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [AW-1:0] src_d, dst_d, cnt_d;
  logic          reject_d;

  // Pointer/count values after the current byte completes
  assign src_d = src_q + AW'(1);
  assign dst_d = dst_q + AW'(1);
  assign cnt_d = cnt_q - AW'(1);

`ifdef DMEM_MASTER_WRAP_CHECK_EN
  logic [AW:0] dst_end, src_end;
  logic        rsp_err_q;
  assign dst_end  = {1'b0, cmd_dst} + {1'b0, cmd_len};
  assign src_end  = {1'b0, cmd_src} + {1'b0, cmd_len};
  // A carry out of the last-byte address means the block would wrap
  assign reject_d = (((cmd_op == OP_COPY) || (cmd_op == OP_FILL)) && dst_end[AW]) ||
                    ((cmd_op == OP_COPY) && src_end[AW]);
  assign rsp_err  = rsp_err_q;
`else
  assign reject_d = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // Control FSM with registered handshake/enable/address outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_e_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
`ifdef DMEM_MASTER_WRAP_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q        <= op_e'(cmd_op);
            src_q       <= cmd_src;
            dst_q       <= cmd_dst;
            cnt_q       <= cmd_len;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            if (reject_d) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
`ifdef DMEM_MASTER_WRAP_CHECK_EN
              rsp_err_q   <= 1'b1;
`endif
            end else if ((cmd_op == OP_LOAD) || (cmd_op == OP_COPY)) begin
              state_q    <= ST_RD;
              mem_e_q    <= 1'b1;
              mem_addr_q <= cmd_src;
            end else begin
              state_q    <= ST_WR;
              mem_e_q    <= 1'b1;
              mem_we_q   <= 1'b1;
              mem_addr_q <= cmd_dst;
            end
          end
        end
        ST_RD: begin
          data_q <= mem_do;
          if (op_q == OP_LOAD) begin
            state_q     <= ST_RESP;
            mem_e_q     <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q    <= ST_WR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= dst_q;
          end
        end
        ST_WR: begin
          src_q <= src_d;
          dst_q <= dst_d;
          cnt_q <= cnt_d;
          if ((op_q == OP_STORE) || (cnt_q == '0)) begin
            state_q     <= ST_RESP;
            mem_e_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b1;
          end else if (op_q == OP_COPY) begin
            state_q    <= ST_RD;
            mem_we_q   <= 1'b0;
            mem_addr_q <= src_d;
          end else begin
            mem_addr_q <= dst_d;
          end
        end
        default: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef DMEM_MASTER_WRAP_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign mem_e     = mem_e_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  // Data lanes decoded from state and data registers only
  assign mem_di    = (state_q == ST_WR) ? ((op_q == OP_COPY) ? data_q : wdata_q) : '0;
  assign rsp_data  = ((state_q == ST_RESP) && (op_q == OP_LOAD)) ? data_q : '0;

endmodule

// File: tb/tb_dmem_master.sv
// tb/tb_dmem_master.sv - self-checking bench for dmem_master against a byte-array reference model
module tb_dmem_master;
  import dmem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_src, cmd_dst, cmd_len;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;
  logic       mem_e, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_di, mem_do;

  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic [4:0] acc_log [$];
  int         rsp_cnt = 0;
  int         tests = 0;
  int         fails = 0;

  dmem_master #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  assign mem_do = mem_e ? mem[mem_addr] : 8'h00;

  // Memory model, access log and response counter
  always @(posedge clk) begin
    if (mem_e && mem_we) mem[mem_addr] <= mem_di;
    if (mem_e) acc_log.push_back({mem_we, mem_addr});
    if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-command effect on a byte array, plus response and latency
  task automatic ref_apply(input logic [1:0] op, input int src, input int dst, input int len,
                           input logic [7:0] wd, output logic [7:0] edata, output logic eerr,
                           output int ecyc);
    edata = 8'h00;
    eerr  = 1'b0;
`ifdef DMEM_MASTER_WRAP_CHECK_EN
    if ((op == OP_COPY || op == OP_FILL) && dst + len > 15) eerr = 1'b1;
    if (op == OP_COPY && src + len > 15) eerr = 1'b1;
`endif
    if (eerr) begin
      ecyc = 1;
    end else begin
      case (op)
        OP_LOAD:  begin edata = ref_mem[src]; ecyc = 2; end
        OP_STORE: begin ref_mem[dst] = wd; ecyc = 2; end
        OP_COPY: begin
          for (int i = 0; i <= len; i++) ref_mem[(dst + i) % 16] = ref_mem[(src + i) % 16];
          ecyc = 2 * (len + 1) + 1;
        end
        default: begin
          for (int i = 0; i <= len; i++) ref_mem[(dst + i) % 16] = wd;
          ecyc = len + 2;
        end
      endcase
    end
  endtask

  // Issue one command, wait for its response, hold it 'hold' cycles, then accept
  task automatic run(input string tag, input logic [1:0] op, input logic [3:0] src,
                     input logic [3:0] dst, input logic [3:0] len, input logic [7:0] wd,
                     input int hold);
    logic [7:0] edata, rdata;
    logic       eerr, rerr;
    int         ecyc, ncyc, budget;
    ref_apply(op, int'(src), int'(dst), int'(len), wd, edata, eerr, ecyc);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_wdata = wd;
    cmd_valid = 1'b1;
    budget = 0;
    while (!cmd_ready && budget < 100) begin tick(); budget++; end
    tick();
    cmd_valid = 1'b0;
    ncyc = 1;
    while (!rsp_valid && ncyc < 100) begin tick(); ncyc++; end
    chk({tag, "_cycles"}, 32'(ncyc), 32'(ecyc));
    rdata = rsp_data;
    rerr  = rsp_err;
    chk({tag, "_data"}, 32'(rdata), 32'(edata));
    chk({tag, "_err"}, 32'(rerr), 32'(eerr));
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int base, budget;
    logic [7:0] held_data;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_e", 32'(mem_e), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_di", 32'(mem_di), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    run("store3", OP_STORE, 4'd0, 4'd3, 4'd0, 8'hA5, 0);
    run("load3", OP_LOAD, 4'd3, 4'd0, 4'd0, 8'h00, 1);
    chk("mem3", 32'(mem[3]), 32'hA5);

    run("store8", OP_STORE, 4'd0, 4'd8, 4'd0, 8'hEE, 0);
    acc_log.delete();
    base = rsp_cnt;
    run("fill4", OP_FILL, 4'd0, 4'd4, 4'd3, 8'h5A, 0);
    chk("fill4_nacc", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      chk("fill4_acc", 32'(acc_log[i]), 32'({1'b1, 4'(4 + i)}));
    tick(); tick();
    chk("fill4_nrsp", 32'(rsp_cnt - base), 32'd1);
    chk("fill4_mem8", 32'(mem[8]), 32'hEE);

    for (int i = 0; i < 8; i++) run("preload", OP_STORE, 4'd0, 4'(i), 4'd0, 8'(8'h10 + i), 0);
    acc_log.delete();
    run("copy", OP_COPY, 4'd0, 4'd8, 4'd7, 8'h00, 0);
    chk("copy_nacc", 32'(acc_log.size()), 32'd16);
    for (int i = 0; i < 8 && 2 * i + 1 < acc_log.size(); i++) begin
      chk("copy_rd", 32'(acc_log[2 * i]), 32'({1'b0, 4'(i)}));
      chk("copy_wr", 32'(acc_log[2 * i + 1]), 32'({1'b1, 4'(8 + i)}));
    end
    for (int i = 8; i < 16; i++) chk("copy_mem", 32'(mem[i]), 32'(8'h10 + i - 8));

    acc_log.delete();
    run("fillwrap", OP_FILL, 4'd0, 4'd14, 4'd3, 8'h77, 0);
`ifdef DMEM_MASTER_WRAP_CHECK_EN
    chk("fillwrap_nacc", 32'(acc_log.size()), 32'd0);
`else
    chk("fillwrap_nacc", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      chk("fillwrap_acc", 32'(acc_log[i]), 32'({1'b1, 4'((14 + i) % 16)}));
`endif

    // Response backpressure with a competing command held on the input
    cmd_op = OP_LOAD; cmd_src = 4'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    budget = 0;
    while (!rsp_valid && budget < 100) begin tick(); budget++; end
    held_data = ref_mem[3];
    cmd_op = OP_STORE; cmd_dst = 4'd9; cmd_wdata = 8'h99; cmd_valid = 1'b1;
    acc_log.delete();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(held_data));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    chk("bp_noacc", 32'(acc_log.size()), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_after", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    ref_mem[9] = 8'h99;
    budget = 0;
    while (!rsp_valid && budget < 100) begin tick(); budget++; end
    chk("bp_store_rsp", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_store_mem", 32'(mem[9]), 32'h99);

    // Reset during the third write of an 8-byte fill
    cmd_op = OP_FILL; cmd_dst = 4'd0; cmd_len = 4'd7; cmd_wdata = 8'hC3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    acc_log.delete();
    base = rsp_cnt;
    tick(); tick();
    chk("rstwr_addr", 32'(mem_addr), 32'd2);
    chk("rstwr_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstwr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstwr_mem_e", 32'(mem_e), 32'd0);
    chk("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (4) tick();
    chk("rstwr_nacc", 32'(acc_log.size()), 32'd3);
    chk("rstwr_nrsp", 32'(rsp_cnt - base), 32'd0);
    chk("rstwr_mem2", 32'(mem[2]), 32'hC3);
    chk("rstwr_mem3", 32'(mem[3]), 32'(ref_mem[3]));
    for (int i = 0; i < 3; i++) ref_mem[i] = 8'hC3;

    // Randomized commands against the reference array
    for (int n = 0; n < 40; n++) begin
      run("rnd", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 16; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
